mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the instruction-fetch port and the data-memory port onto one shared SRAM-like bus with a request/address-ok/data-ok handshake. Only one transaction is outstanding at a time. The block drives the `i_stall` and `d_stall` inputs of the hazard unit, which combines them into the global pipeline stall. It sits between the core pipeline (IF and MEM stages) and the bus bridge.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width

Ports:
- `clk` in 1: core clock, rising edge
- `resetn` in 1: asynchronous, active-low reset
- `inst_req` in 1: fetch request; held with `inst_addr` until `inst_ok`
- `inst_addr` in AW: fetch address
- `inst_rdata` out DW: fetched word; valid in the `inst_ok` cycle
- `inst_ok` out 1: one-cycle completion pulse
- `data_req` in 1: load/store request; held stable until `data_ok`
- `data_wr` in 1: 1 = store
- `data_size` in 2: 0 = byte, 1 = half, 2 = word
- `data_addr` in AW: data address
- `data_wdata` in DW: store data
- `data_rdata` out DW: load data; valid in the `data_ok` cycle
- `data_ok` out 1: one-cycle completion pulse
- `bus_req` out 1: bus request
- `bus_wr` out 1: bus write
- `bus_size` out 2: bus transfer size
- `bus_addr` out AW: bus address
- `bus_wdata` out DW: bus write data
- `bus_addr_ok` in 1: address accepted
- `bus_data_ok` in 1: transfer complete
- `bus_rdata` in DW: read data
- `i_stall` out 1: `inst_req & ~inst_ok`
- `d_stall` out 1: `data_req & ~data_ok`

## Operation
FSM states:
- **IDLE**: on a sampled request, pick a grant and latch the winner's `wr`, `size`, `addr` and `wdata` into bus registers, then go to ADDR. A fetch always drives `bus_wr=0` and `bus_size=2`.
- **ADDR**: `bus_req=1`. If `bus_addr_ok` arrives without `bus_data_ok`, go to DATA and drop `bus_req`. If `bus_addr_ok` and `bus_data_ok` arrive together, go to RESP.
- **DATA**: wait for `bus_data_ok`, then go to RESP.
- **RESP**: register `bus_rdata` into the granted port's rdata and pulse that port's ok if its req is still high. Return to IDLE.

Rules:
- Grant, fixed priority: data beats instruction, because MEM is the older instruction.
- Grant is latched and does not change until the FSM returns to IDLE.
- If the granted requester drops req mid-transaction (pipeline flush), the bus transaction still completes, and ok is suppressed.
- `bus_data_ok` is ignored in IDLE. `bus_addr_ok` is ignored outside ADDR.
- Each port's rdata holds its last value between transactions.
- `i_stall` and `d_stall` are combinational. A requester that is waiting on a transaction for the other port sees its stall held high.

Reset values: state IDLE; all ok outputs, `bus_req`, `bus_wr`, `bus_size` and `bus_addr` are 0; rdata is 0; grant is DATA.

## Timing
- Request high in IDLE at cycle N: `bus_req` is high from N+1.
- `bus_addr_ok` at cycle A gives `bus_req` low at A+1.
- `bus_data_ok` at cycle D gives ok and rdata at D+2 (RESP entered at D+1 holds the registered data for one cycle). IDLE is re-entered at D+2.
- Minimum latency with zero-wait bus (`addr_ok` and `data_ok` both at N+1): ok at N+3. Next grant at N+3, so back-to-back throughput is one transaction per 3 cycles.
- Simultaneous `inst_req` and `data_req` in IDLE: data is served first. The instruction is granted in the IDLE cycle after data's RESP.
- An asynchronous reset mid-transaction aborts it: `bus_req` drops immediately and no ok is produced. The bus bridge is reset by the same `resetn`.

## Configuration
Macro `MEM_ARB_RR_EN`:
- **Defined**: round-robin arbitration. A 1-bit last-grant register (reset value INST) is kept. On simultaneous requests, the port not granted last wins. A single requester always wins.
- **Undefined**: fixed data-first priority. No last-grant register is instantiated.

## Structure
- `mem_arb_pkg` holds:
  - state enum (IDLE, ADDR, DATA, RESP)
  - grant-id constants (`GNT_INST`, `GNT_DATA`)
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`)
- Sub-module `mem_arb_grant` holds the combinational pick plus the optional last-grant flop. Its inputs are the two requests and a grant-enable; its output is the grant-id.
- The top module holds the FSM, the latched bus registers and the response registers.

## Test plan
- Fetch only, addr 0x00400000, zero-wait bus returning 0x24080001: `bus_req` high N+1, `inst_ok` at N+3, `inst_rdata=0x24080001`, `i_stall` high N..N+2.
- Simultaneous fetch at 0x00400004 and store (word 0xDEADBEEF to 0x10000000): first bus transaction has `bus_wr=1`, `bus_addr=0x10000000`, size 2. The fetch follows it. `i_stall` stays high until the second ok.
- `bus_addr_ok` delayed 3 cycles, then `bus_data_ok` 2 cycles later: `bus_req` held high 4 cycles with stable addr, ok exactly 2 cycles after `bus_data_ok`, single pulse.
- `inst_req` dropped during DATA: bus transaction completes, `inst_ok` stays 0, FSM returns to IDLE and accepts a pending `data_req` next.
- `resetn` low during DATA: `bus_req`, ok and state cleared asynchronously. After release, a fresh request completes normally.
- With `MEM_ARB_RR_EN`, both requesters held high continuously: grants alternate DATA, INST, DATA, INST (first grant DATA, since the last-grant reset value is INST).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant ids
// and transfer-size encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant pick between fetch and data requests. Fixed data-first priority by
// default; `MEM_ARB_RR_EN enables round-robin with a last-grant flop.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic i_inst_req,
  input  logic i_data_req,
  input  logic i_gnt_en,
  output logic o_gnt
);

`ifdef MEM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       r_last <= GNT_INST;
    else if (i_gnt_en) r_last <= o_gnt;
  end

  // On a tie the port that did not win last time goes next.
  always_comb begin
    if (i_inst_req && i_data_req) o_gnt = ~r_last;
    else if (i_inst_req)          o_gnt = GNT_INST;
    else                          o_gnt = GNT_DATA;
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, resetn, i_gnt_en};

  // MEM holds the older instruction, so data wins any tie.
  assign o_gnt = (i_inst_req && !i_data_req) ? GNT_INST : GNT_DATA;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and MEM ports onto one SRAM-like bus, one transaction in flight.
// Build option: `MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_ok,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_ok,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata,
  output logic          i_stall,
  output logic          d_stall
);

  state_t        r_state, w_next;
  logic          r_gnt, w_gnt;
  logic          w_inst_req, w_data_req, w_start;
  logic          r_bus_wr;
  logic [1:0]    r_bus_size;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;
  logic [DW-1:0] r_rbuf, r_inst_rdata, r_data_rdata;
  logic          r_inst_ok, r_data_ok;

  // A port whose ok pulses this cycle is finished; its req is not a new one.
  assign w_inst_req = inst_req & ~r_inst_ok;
  assign w_data_req = data_req & ~r_data_ok;
  assign w_start    = (r_state == ST_IDLE) & (w_inst_req | w_data_req);

  mem_arb_grant u_grant (
    .clk       (clk),
    .resetn    (resetn),
    .i_inst_req(w_inst_req),
    .i_data_req(w_data_req),
    .i_gnt_en  (w_start),
    .o_gnt     (w_gnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_ADDR;
      ST_ADDR: if (bus_addr_ok) w_next = bus_data_ok ? ST_RESP : ST_DATA;
      ST_DATA: if (bus_data_ok) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gnt       <= GNT_DATA;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= 2'd0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else if (w_start) begin
      r_gnt <= w_gnt;
      if (w_gnt == GNT_DATA) begin
        r_bus_wr    <= data_wr;
        r_bus_size  <= data_size;
        r_bus_addr  <= data_addr;
        r_bus_wdata <= data_wdata;
      end else begin
        r_bus_wr    <= 1'b0;
        r_bus_size  <= SZ_WORD;
        r_bus_addr  <= inst_addr;
        r_bus_wdata <= '0;
      end
    end
  end

  // Read data is buffered on entry to RESP and handed to the port one cycle later;
  // ok is dropped if the requester was flushed meanwhile.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rbuf       <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
    end else begin
      r_inst_ok <= 1'b0;
      r_data_ok <= 1'b0;
      if (w_next == ST_RESP) r_rbuf <= bus_rdata;
      if (r_state == ST_RESP) begin
        if (r_gnt == GNT_DATA) begin
          r_data_rdata <= r_rbuf;
          r_data_ok    <= data_req;
        end else begin
          r_inst_rdata <= r_rbuf;
          r_inst_ok    <= inst_req;
        end
      end
    end
  end

  assign bus_req    = (r_state == ST_ADDR);
  assign bus_wr     = r_bus_wr;
  assign bus_size   = r_bus_size;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;
  assign inst_ok    = r_inst_ok;
  assign data_ok    = r_data_ok;
  assign i_stall    = inst_req & ~r_inst_ok;
  assign d_stall    = data_req & ~r_data_ok;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: bus-slave model with scoreboards for
// bus transactions and port responses, plus per-scenario timing checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        i_stall, d_stall;

  typedef struct { logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } bus_t;
  typedef struct { logic port; logic [31:0] rdata; } rsp_t;  // port 1 = data, 0 = inst

  bus_t bq[$];
  rsp_t rq[$];
  int n_checks = 0;
  int n_fail = 0;
  int aw_cfg = 0;
  int dw_cfg = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .i_stall(i_stall), .d_stall(d_stall)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h2408_0001 : ((a ^ 32'h5A5A_0000) + 32'd7);
  endfunction

  task automatic exp_bus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus_t e;
    e.wr = wr; e.size = size; e.addr = addr; e.wdata = wdata;
    bq.push_back(e);
  endtask

  task automatic exp_rsp(input logic port, input logic [31:0] rdata);
    rsp_t e;
    e.port = port; e.rdata = rdata;
    rq.push_back(e);
  endtask

  // Bus slave: addr_ok aw_cfg cycles after bus_req rises, data_ok dw_cfg cycles after addr_ok.
  initial begin : slave
    int ph, acnt, dcnt;
    logic [31:0] cur;
    ph = 0; acnt = 0; dcnt = 0; cur = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (!resetn) begin
        ph = 0;
      end else begin
        if (ph == 0 && bus_req === 1'b1) begin
          n_checks++;
          if (bq.size() == 0) begin
            n_fail++;
            $display("FAIL bus_unexpected: bus_req=1 addr=%h, required no request", bus_addr);
          end else begin
            bus_t e;
            e = bq.pop_front();
            if (bus_wr !== e.wr || bus_size !== e.size || bus_addr !== e.addr ||
                (e.wr && bus_wdata !== e.wdata)) begin
              n_fail++;
              $display("FAIL bus_txn: got wr=%b size=%0d addr=%h wdata=%h, required wr=%b size=%0d addr=%h wdata=%h",
                       bus_wr, bus_size, bus_addr, bus_wdata, e.wr, e.size, e.addr, e.wdata);
            end
          end
          cur = bus_addr; acnt = aw_cfg; ph = 1;
        end
        if (ph == 1) begin
          n_checks++;
          if (bus_req !== 1'b1 || bus_addr !== cur) begin
            n_fail++;
            $display("FAIL bus_hold: bus_req=%b addr=%h, required 1 addr=%h", bus_req, bus_addr, cur);
          end
          if (acnt == 0) begin bus_addr_ok = 1'b1; dcnt = dw_cfg; ph = 2; end
          else acnt--;
        end
        if (ph == 2) begin
          if (dcnt == 0) begin bus_data_ok = 1'b1; bus_rdata = mem_fn(cur); ph = 0; end
          else dcnt--;
        end
      end
    end
  end

  // Response monitor: every ok pulse must match the next expected response.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (inst_ok === 1'b1) begin
        n_checks++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL inst_ok_unexpected: inst_ok=1, required 0");
        end else begin
          rsp_t e;
          e = rq.pop_front();
          if (e.port !== 1'b0 || inst_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL inst_rsp: port=inst rdata=%h, required port=%0d rdata=%h", inst_rdata, e.port, e.rdata);
          end
        end
      end
      if (data_ok === 1'b1) begin
        n_checks++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL data_ok_unexpected: data_ok=1, required 0");
        end else begin
          rsp_t e;
          e = rq.pop_front();
          if (e.port !== 1'b1 || data_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL data_rsp: port=data rdata=%h, required port=%0d rdata=%h", data_rdata, e.port, e.rdata);
          end
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_wr, bus_size, bus_addr, inst_ok, data_ok} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: req=%b wr=%b size=%0d addr=%h iok=%b dok=%b, required all 0",
               bus_req, bus_wr, bus_size, bus_addr, inst_ok, data_ok);
    end
    n_checks++;
    if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: inst=%h data=%h, required 0", inst_rdata, data_rdata);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0040_0000;
    exp_bus(1'b0, 2'd2, 32'h0040_0000, 32'h0);
    exp_rsp(1'b0, 32'h2408_0001);
    #1;
    n_checks++;
    if (i_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall0: i_stall=%b, required 1", i_stall); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_req !== (k == 1)) begin n_fail++; $display("FAIL fetch_bus_req k=%0d: %b, required %b", k, bus_req, k == 1); end
      n_checks++;
      if (inst_ok !== (k == 3)) begin n_fail++; $display("FAIL fetch_ok k=%0d: %b, required %b", k, inst_ok, k == 3); end
      n_checks++;
      if (i_stall !== (k < 3)) begin n_fail++; $display("FAIL fetch_stall k=%0d: %b, required %b", k, i_stall, k < 3); end
      if (k == 3) inst_req = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    bit done;
    done = 1'b0;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0040_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h1000_0000; data_wdata = 32'hDEAD_BEEF;
    exp_bus(1'b1, 2'd2, 32'h1000_0000, 32'hDEAD_BEEF);
    exp_bus(1'b0, 2'd2, 32'h0040_0004, 32'h0);
    exp_rsp(1'b1, mem_fn(32'h1000_0000));
    exp_rsp(1'b0, mem_fn(32'h0040_0004));
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (!inst_ok) begin
        n_checks++;
        if (i_stall !== 1'b1) begin n_fail++; $display("FAIL simul_stall k=%0d: i_stall=%b, required 1", k, i_stall); end
      end
      if (data_ok) begin
        n_checks++;
        if (k != 3 || inst_rdata !== 32'h2408_0001) begin
          n_fail++;
          $display("FAIL simul_data_ok: at k=%0d inst_rdata=%h, required k=3 inst_rdata=24080001", k, inst_rdata);
        end
        data_req = 1'b0; data_wr = 1'b0;
      end
      if (inst_ok) begin
        n_checks++;
        if (k != 6) begin n_fail++; $display("FAIL simul_inst_ok: at k=%0d, required k=6", k); end
        inst_req = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin n_checks++; n_fail++; $display("FAIL simul_timeout: inst_ok not seen, required within 20 cycles"); end
  endtask

  task automatic test_wait_states();
    aw_cfg = 3; dw_cfg = 2;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0040_0008;
    exp_bus(1'b0, 2'd2, 32'h0040_0008, 32'h0);
    exp_rsp(1'b0, mem_fn(32'h0040_0008));
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_req !== (k <= 4)) begin n_fail++; $display("FAIL wait_bus_req k=%0d: %b, required %b", k, bus_req, k <= 4); end
      n_checks++;
      if (inst_ok !== (k == 8)) begin n_fail++; $display("FAIL wait_ok k=%0d: %b, required %b", k, inst_ok, k == 8); end
      if (k == 8) inst_req = 1'b0;
    end
    aw_cfg = 0; dw_cfg = 0;
  endtask

  task automatic test_flush();
    aw_cfg = 0; dw_cfg = 3;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0040_000C;
    exp_bus(1'b0, 2'd2, 32'h0040_000C, 32'h0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 2) begin
        inst_req = 1'b0; dw_cfg = 0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h1000_0013;
        exp_bus(1'b0, 2'd0, 32'h1000_0013, 32'h0);
        exp_rsp(1'b1, mem_fn(32'h1000_0013));
      end
      n_checks++;
      if (inst_ok !== 1'b0) begin n_fail++; $display("FAIL flush_inst_ok k=%0d: %b, required 0", k, inst_ok); end
      n_checks++;
      if (bus_req !== (k == 1 || k == 7)) begin n_fail++; $display("FAIL flush_bus_req k=%0d: %b, required %b", k, bus_req, (k == 1 || k == 7)); end
      n_checks++;
      if (data_ok !== (k == 9)) begin n_fail++; $display("FAIL flush_data_ok k=%0d: %b, required %b", k, data_ok, k == 9); end
      if (k == 5) begin
        n_checks++;
        if (d_stall !== 1'b1) begin n_fail++; $display("FAIL flush_d_stall: %b, required 1", d_stall); end
      end
      if (k == 9) data_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    aw_cfg = 0; dw_cfg = 5;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0040_0010;
    exp_bus(1'b0, 2'd2, 32'h0040_0010, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || inst_ok !== 1'b0 || bus_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: bus_req=%b inst_ok=%b bus_addr=%h, required 0 0 0", bus_req, inst_ok, bus_addr);
    end
    inst_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b0 || inst_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_hold: bus_req=%b inst_rdata=%h, required 0 0", bus_req, inst_rdata);
    end
    resetn = 1'b1; dw_cfg = 0;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0040_0014;
    exp_bus(1'b0, 2'd2, 32'h0040_0014, 32'h0);
    exp_rsp(1'b0, mem_fn(32'h0040_0014));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (inst_ok !== (k == 3)) begin n_fail++; $display("FAIL rstmid_fresh_ok k=%0d: %b, required %b", k, inst_ok, k == 3); end
      if (k == 3) inst_req = 1'b0;
    end
  endtask

`ifdef MEM_ARB_RR_EN
  task automatic test_round_robin();
    int n_ok;
    n_ok = 0;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0040_0020;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h1000_0020;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin exp_bus(1'b0, 2'd2, 32'h1000_0020, 32'h0); exp_rsp(1'b1, mem_fn(32'h1000_0020)); end
      else            begin exp_bus(1'b0, 2'd2, 32'h0040_0020, 32'h0); exp_rsp(1'b0, mem_fn(32'h0040_0020)); end
    end
    for (int k = 1; k <= 30 && n_ok < 4; k++) begin
      @(negedge clk);
      if (data_ok || inst_ok) begin
        n_checks++;
        if (data_ok !== (n_ok % 2 == 0)) begin
          n_fail++;
          $display("FAIL rr_order: ok #%0d data_ok=%b, required %b", n_ok, data_ok, n_ok % 2 == 0);
        end
        n_ok++;
        if (n_ok == 3) data_req = 1'b0;
        if (n_ok == 4) inst_req = 1'b0;
      end
    end
    n_checks++;
    if (n_ok != 4) begin n_fail++; $display("FAIL rr_timeout: oks=%0d, required 4", n_ok); inst_req = 1'b0; data_req = 1'b0; end
  endtask
`endif

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_fetch();
    test_simultaneous();
    test_wait_states();
    test_flush();
    test_reset_mid();
`ifdef MEM_ARB_RR_EN
    test_round_robin();
`endif
    repeat (4) @(negedge clk);
    n_checks++;
    if (bq.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: bus_pending=%0d rsp_pending=%0d, required 0 0", bq.size(), rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
